// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: access size encodings and FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ST0,
        ST1,
        LD0,
        LD1,
        LDW,
        RESP,
        ERR
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from a pair of memory words and sign/zero-extends them.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = 32'(words >> {off, 3'b000});
        case (size)
            SZ_B:    result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_rv32i.sv
// Load/store unit driving a registered-read, byte-enabled word memory; word-crossing
// accesses are either split into two word accesses or rejected, depending on SPLIT_MISALIGNED.
module lsu_rv32i
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 8,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t state, next_state;

    logic [1:0]        off_q, size_q;
    logic              unsigned_q, cross_q;
    logic [ADDR_W-1:0] w0_q, w1_q;
    logic [7:0]        be_q;
    logic [63:0]       data_q;
    logic [31:0]       word0_q, rdata_q;

    logic              accept, cross_req;
    logic [2:0]        n_req;
    logic [3:0]        mask_req;
    logic [31:0]       load_result;
    logic              unused_addr_bits;

    assign accept           = req_valid && req_ready;
    assign n_req            = size_bytes(req_size);
    assign cross_req        = ({1'b0, req_addr[1:0]} + n_req) > 3'd4;
    assign mask_req         = (n_req == 3'd1) ? 4'b0001 : (n_req == 3'd2) ? 4'b0011 : 4'b1111;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
    assign resp_rdata       = rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            off_q      <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            cross_q    <= 1'b0;
            w0_q       <= '0;
            w1_q       <= '0;
            be_q       <= '0;
            data_q     <= '0;
            word0_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                off_q      <= req_addr[1:0];
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                cross_q    <= cross_req;
                w0_q       <= req_addr[ADDR_W+1:2];
                w1_q       <= req_addr[ADDR_W+1:2] + ADDR_W'(1);
                be_q       <= {4'b0000, mask_req} << req_addr[1:0];
                data_q     <= {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
            end
            if (state == LD1)
                word0_q <= mem_rdata;
            // Stores and errors report zero; only a completing load carries data.
            if (next_state == RESP || next_state == ERR)
                rdata_q <= (state == LDW) ? load_result : '0;
        end
    end

    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        mem_addr    = '0;
        mem_wren    = 1'b0;
        mem_byteena = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_size == 2'b11 || (cross_req && !SPLIT_MISALIGNED))
                        next_state = ERR;
                    else if (req_store)
                        next_state = ST0;
                    else
                        next_state = LD0;
                end
            end
            ST0: begin
                mem_wren    = 1'b1;
                mem_addr    = w0_q;
                mem_byteena = be_q[3:0];
                mem_wdata   = data_q[31:0];
                next_state  = cross_q ? ST1 : RESP;
            end
            ST1: begin
                mem_wren    = 1'b1;
                mem_addr    = w1_q;
                mem_byteena = be_q[7:4];
                mem_wdata   = data_q[63:32];
                next_state  = RESP;
            end
            LD0: begin
                mem_addr   = w0_q;
                next_state = cross_q ? LD1 : LDW;
            end
            LD1: begin
                mem_addr   = w1_q;
                next_state = LDW;
            end
            LDW: begin
                mem_addr   = cross_q ? w1_q : w0_q;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The last word arrives on mem_rdata during LDW; word0 was captured in LD1 when split.
    lsu_load_align u_align (
        .words       (cross_q ? {mem_rdata, word0_q} : {32'b0, mem_rdata}),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_result)
    );

endmodule

// File: doc/lsu_rv32i.md
Name: lsu_rv32i

Overview:
Load/store unit that acts as initiator toward the single-port, byte-enabled data memory (256 x 32-bit). It accepts one load or store request at a time from the core and issues word-addressed memory accesses with byte enables and aligned write data. For loads, it extracts and sign- or zero-extends the addressed bytes from the returned read data. Misaligned accesses that cross a word boundary are split into two sequential word accesses.

Parameters:
ADDR_W, 8, memory word-address width; 256 words.
SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = reject them with resp_err.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready.
req_store  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  in  1  load only: 1 = zero-extend (LBU/LHU).
req_addr  in  32  byte address.
req_wdata  in  32  store data, LSB-justified.
resp_valid  out  1  one-cycle completion pulse; no backpressure.
resp_err  out  1  qualifies resp_valid: illegal size, or misaligned access with SPLIT_MISALIGNED=0.
resp_rdata  out  32  extended load data; 0 for stores and errors; held until the next response.
mem_addr  out  ADDR_W  word address.
mem_wren  out  1  write enable.
mem_byteena  out  4  byte enables.
mem_wdata  out  32  byte-positioned write data.
mem_rdata  in  32  read data, valid one cycle after mem_addr is presented (registered read).

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wren=0, mem_byteena=0, mem_addr=0, mem_wdata=0; state is IDLE.
- Request latch, at acceptance cycle T:
  - off = addr[1:0]; n = 1/2/4 bytes.
  - w0 = addr[ADDR_W+1:2]; w1 = w0+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - Address bits above ADDR_W+1 are ignored.
  - cross = (off+n > 4).
- Store lane math:
  - 8-bit mask = ((1<<n)-1) << off.
  - 64-bit data = zero-extended req_wdata << (8*off).
  - Low half goes to w0, high half to w1.
- States: IDLE, ST0, ST1, LD0, LD1, LDW, RESP, ERR.
- IDLE: req_ready=1; memory outputs idle (mem_wren=0). On accept:
  - size==11 → ERR.
  - cross && SPLIT_MISALIGNED==0 → ERR.
  - store → ST0; load → LD0.
- ST0: mem_wren=1, mem_addr=w0, low byteena/data. Next state: cross ? ST1 : RESP.
- ST1: mem_wren=1, mem_addr=w1, high byteena/data. Next state: RESP.
- LD0: mem_addr=w0, mem_wren=0. Next state: cross ? LD1 : LDW.
- LD1: mem_addr=w1; capture mem_rdata as word0. Next state: LDW.
- LDW: capture mem_rdata as the last word (word0 if not cross, else word1). Next state: RESP.
- Load extraction (RESP):
  - Take bytes [off .. off+n-1] of {word1, word0}.
  - Sign-extend from bit 8n-1 unless req_unsigned.
  - req_unsigned is ignored for word loads.
- RESP: resp_valid=1, resp_err=0, resp_rdata updated. Next state: IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory access. Next state: IDLE.
- Latency (T = acceptance cycle):
  - aligned store: writes in T+1, resp at T+2.
  - split store: writes in T+1 and T+2, resp at T+3.
  - aligned load: resp at T+3.
  - split load: resp at T+4.
  - error: resp at T+1.
- req_ready=0 in every non-IDLE state; back-to-back throughput is one request per completion+1 cycle.
- Reset mid-operation: on the edge where reset is sampled high, all state and outputs return to reset values and no response is issued. A split store interrupted after ST0 leaves word0 written; this is accepted and not rolled back.
- Inputs req_* are sampled only at acceptance; later changes have no effect.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10 (common with the data memory's store-type encoding);
  - state enum.
- One combinational sub-module, lsu_load_align: inputs {word1, word0}, off, size, unsigned; output is the extended 32-bit result.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF → T+1: mem_addr=0x04, be=1111, wdata=DEADBEEF, wren=1. T+2: resp_valid=1, err=0.
2. Word 4 = 0x80332211. LB addr 0x13 → resp_rdata=0xFFFFFF80. LBU addr 0x13 → 0x00000080. LH addr 0x10 → 0x00002211.
3. Split SW addr 0x0E, data 0xAABBCCDD:
   - T+1: addr 3, be=1100, wdata=0xCCDD0000.
   - T+2: addr 4, be=0011, wdata=0x0000AABB.
   - resp at T+3.
4. Wrap load: word 0xFF = 0x12000000, word 0 = 0x000000F4. LH addr 0x3FF → reads word 0xFF then word 0x00, resp at T+4 with rdata=0xFFFFF412. LHU same address → 0x0000F412.
5. Errors:
   - req_size=11 → resp_valid=1, resp_err=1 at T+1, mem_wren never asserted.
   - SPLIT_MISALIGNED=0, LW addr 0x02 → err at T+1, no memory access.
6. Assert reset during ST0 of split store at addr 0x0E → word 3 written, word 4 unchanged, no resp_valid; req_ready=1 on the cycle after reset.
